// File: rtl/inertial_delay_filter_if.sv
// Signal bundle for inertial_delay_filter.
//   master: drives the raw event (a), mode select and counter clear.
//   slave : returns the delayed/filtered signal, glitch count and pending flag.
interface inertial_delay_filter_if #(
  parameter int unsigned CNT_W = 8
);
  logic             a;
  logic             mode;
  logic             clr_cnt;
  logic             out;
  logic [CNT_W-1:0] glitch_cnt;
  logic             pending;

  modport master (output a, mode, clr_cnt, input out, glitch_cnt, pending);
  modport slave  (input a, mode, clr_cnt, output out, glitch_cnt, pending);
endinterface

// File: rtl/inertial_delay_filter.sv
// Cycle-accurate transport/inertial delay stage for a single-bit event.
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset
//   bus.a          : raw input, sampled every edge
//   bus.mode       : 0 = transport, 1 = inertial (reject pulses < GLITCH_W)
//   bus.clr_cnt    : synchronous clear of glitch_cnt (wins over increment)
//   bus.out        : delayed/filtered signal (registered)
//   bus.glitch_cnt : saturating count of rejected pulses (registered)
//   bus.pending    : a transition is still in flight (combinational)
module inertial_delay_filter #(
  parameter int unsigned DELAY    = 5,
  parameter int unsigned GLITCH_W = 3,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  inertial_delay_filter_if.slave bus
);

  localparam int unsigned QW      = (GLITCH_W > 1) ? $clog2(GLITCH_W) : 1;
  localparam bit          QUAL_EN = (GLITCH_W > 1);
  localparam logic [QW-1:0]    QLAST   = QW'(GLITCH_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {STABLE = 1'b0, QUALIFY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic             f_q, f_d;
  logic             reject_c;
  logic [CNT_W-1:0] cnt_q;
  // pipe_q[DELAY-1] is the out register; lower indices form the line.
  logic [DELAY-1:0] pipe_q;
  logic             line_in;

  assign line_in = bus.mode ? f_q : bus.a;

  // State register plus filter, counter and delay-line registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      qcnt_q  <= '0;
      f_q     <= 1'b0;
      cnt_q   <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      f_q     <= f_d;
      if (bus.clr_cnt) begin
        cnt_q <= '0;
      end else if (reject_c && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      pipe_q[0] <= line_in;
      for (int unsigned i = 1; i < DELAY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Next-state logic; transport mode pins the filter in STABLE.
  always_comb begin
    state_d = state_q;
    if (!bus.mode) begin
      state_d = STABLE;
    end else begin
      case (state_q)
        STABLE: begin
          if ((bus.a != f_q) && QUAL_EN) state_d = QUALIFY;
        end
        QUALIFY: begin
          if ((bus.a == f_q) || (qcnt_q == QLAST)) state_d = STABLE;
        end
        default: state_d = STABLE;
      endcase
    end
  end

  // Filter outputs: new f, qualification count and reject strobe.
  always_comb begin
    f_d      = f_q;
    qcnt_d   = qcnt_q;
    reject_c = 1'b0;
    if (!bus.mode) begin
      // Tracking a keeps f equal to the last sample, so re-entering
      // inertial mode never creates a spurious edge.
      f_d    = bus.a;
      qcnt_d = '0;
    end else begin
      case (state_q)
        STABLE: begin
          if (bus.a != f_q) begin
            if (QUAL_EN) qcnt_d = QW'(1);
            else         f_d    = bus.a;
          end
        end
        QUALIFY: begin
          if (bus.a == f_q) begin
            reject_c = 1'b1;
            qcnt_d   = '0;
          end else if (qcnt_q == QLAST) begin
            f_d    = ~f_q;
            qcnt_d = '0;
          end else begin
            qcnt_d = qcnt_q + QW'(1);
          end
        end
        default: begin
          qcnt_d = '0;
        end
      endcase
    end
  end

  assign bus.out        = pipe_q[DELAY-1];
  assign bus.glitch_cnt = cnt_q;
  // In flight: qualifying, any stage differing from out, or a new value at the line input.
  assign bus.pending    = (state_q == QUALIFY) ||
                          (pipe_q != {DELAY{pipe_q[DELAY-1]}}) ||
                          (line_in != pipe_q[0]);

endmodule

// File: tb/tb_inertial_delay_filter.sv
// Self-checking bench for inertial_delay_filter (DELAY=5, GLITCH_W=3, CNT_W=8).
module tb_inertial_delay_filter;

  localparam int unsigned DELAY    = 5;
  localparam int unsigned GLITCH_W = 3;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned MAXC     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inertial_delay_filter_if #(.CNT_W(CNT_W)) bus ();

  inertial_delay_filter #(
    .DELAY(DELAY), .GLITCH_W(GLITCH_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  bit          chk_en = 1'b0;

  // Behavioural model: f is the accepted level, run is how many consecutive
  // inertial samples have disagreed with it; hist holds the values entering
  // the line, newest first, so hist[DELAY-1] is what out must show.
  bit          m_f;
  int unsigned m_run;
  int unsigned m_cnt;
  bit          m_hist[$];

  always @(posedge clk) begin : model
    bit lin;
    if (rst) begin
      m_f   = 1'b0;
      m_run = 0;
      m_cnt = 0;
      m_hist.delete();
      for (int i = 0; i < DELAY; i++) m_hist.push_back(1'b0);
    end else begin
      lin = bus.mode ? m_f : bus.a;
      m_hist.push_front(lin);
      void'(m_hist.pop_back());
      if (!bus.mode) begin
        m_f   = bus.a;
        m_run = 0;
      end else if (bus.a != m_f) begin
        m_run++;
        if (m_run == GLITCH_W) begin
          m_f   = ~m_f;
          m_run = 0;
        end
      end else begin
        if ((m_run > 0) && (m_cnt < MAXC)) m_cnt++;
        m_run = 0;
      end
      if (bus.clr_cnt) m_cnt = 0;
    end
  end

  function automatic bit m_pending();
    bit lin;
    lin = bus.mode ? m_f : bus.a;
    if (m_run != 0) return 1'b1;
    if (lin != m_hist[0]) return 1'b1;
    for (int i = 0; i < DELAY - 1; i++)
      if (m_hist[i] != m_hist[DELAY-1]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out",     32'(bus.out),        32'(m_hist[DELAY-1]));
      check("model_cnt",     32'(bus.glitch_cnt), 32'(m_cnt));
      check("model_pending", 32'(bus.pending),    32'(m_pending()));
    end
  end

  // Set inputs just after an edge and hold them for n edges.
  task automatic drive(bit av, bit mv, bit cv, bit rv, int unsigned n);
    bus.a       = av;
    bus.mode    = mv;
    bus.clr_cnt = cv;
    rst         = rv;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [63:0] pat_a;
  logic [63:0] pat_m;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2);
    chk_en = 1'b1;
    check("reset_out",     32'(bus.out),        32'd0);
    check("reset_cnt",     32'(bus.glitch_cnt), 32'd0);
    check("reset_pending", 32'(bus.pending),    32'd0);

    // Transport: a set after an edge shows on out DELAY edges later.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3);
    drive(1'b1, 1'b0, 1'b0, 1'b0, DELAY - 1);
    check("tp_rise_early", 32'(bus.out), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
    check("tp_rise", 32'(bus.out), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, DELAY + 1);
    // 1-cycle pulse survives with its width intact.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, DELAY - 2);
    check("tp_pulse_early", 32'(bus.out), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("tp_pulse_high", 32'(bus.out), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("tp_pulse_end", 32'(bus.out), 32'd0);
    check("tp_cnt", 32'(bus.glitch_cnt), 32'd0);

    // Inertial accept: 3-sample pulse, delayed by GLITCH_W+DELAY, width kept.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1);
    check("ia_pending", 32'(bus.pending), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, GLITCH_W - 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, DELAY - 1);
    check("ia_early", 32'(bus.out), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    check("ia_rise", 32'(bus.out), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, GLITCH_W - 1);
    check("ia_hold", 32'(bus.out), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    check("ia_fall", 32'(bus.out), 32'd0);
    check("ia_cnt", 32'(bus.glitch_cnt), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, DELAY + 2);

    // Inertial reject: 2-sample pulse is dropped and counted.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1);
    check("ir_pending0", 32'(bus.pending), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1);
    check("ir_pending1", 32'(bus.pending), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    check("ir_cnt", 32'(bus.glitch_cnt), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, DELAY + 1);
    check("ir_out", 32'(bus.out), 32'd0);

    // Saturation and clear.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
    check("clr_cnt", 32'(bus.glitch_cnt), 32'd0);
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    end
    check("sat_cnt", 32'(bus.glitch_cnt), 32'd255);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1);
    end
    check("pre_clr_cnt", 32'(bus.glitch_cnt), 32'd2);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1);
    check("clr_wins", 32'(bus.glitch_cnt), 32'd0);

    // Mode switch mid-qualify: abandoned, not counted.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1);
    check("ms_pending", 32'(bus.pending), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
    check("ms_cnt", 32'(bus.glitch_cnt), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, DELAY + 1);
    check("ms_out", 32'(bus.out), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, DELAY + 2);

    // Reset mid-flight discards a line full of 1s.
    drive(1'b1, 1'b0, 1'b0, 1'b0, DELAY + 1);
    check("rf_full", 32'(bus.out), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
    check("rf_out", 32'(bus.out), 32'd0);
    check("rf_pending", 32'(bus.pending), 32'd0);
    for (int i = 0; i < DELAY; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1);
      check("rf_quiet", 32'(bus.out), 32'd0);
    end

    // Mixed-mode burst checked against the model only.
    pat_a = 64'hB3A5_0F1C_7E42_9D68;
    pat_m = 64'hFFFF_00FF_F0F0_FFC3;
    for (int i = 0; i < 64; i++) drive(pat_a[i], pat_m[i], 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, DELAY + 2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
